// File: rtl/pspin_ctrl_axil_master.sv
// Single-outstanding AXI-Lite master for the PsPIN control-register slave.
// One command in, one AXI-Lite transaction, one response out; the response phase can time out.
module pspin_ctrl_axil_master #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP,
        ORPHAN
    } state_t;

    localparam int unsigned LSB_W = $clog2(STRB_WIDTH);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << LSB_W) - 1);

    state_t                state;
    logic                  is_write;
    logic                  orphan;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      tmo_cnt;
    logic                  tmo_hit;
    logic                  aw_done;
    logic                  w_done;

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    // A channel is done once its valid has dropped or it handshakes this cycle.
    assign aw_done = !m_axil_awvalid || m_axil_awready;
    assign w_done  = !m_axil_wvalid  || m_axil_wready;

    // Expiry is evaluated on the last waiting cycle; a beat in that same cycle takes priority.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && ((32'(tmo_cnt) + 32'd1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            is_write       <= 1'b0;
            orphan         <= 1'b0;
            addr_q         <= '0;
            tmo_cnt        <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            rsp_timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_write     <= cmd_write;
                        orphan       <= 1'b0;
                        addr_q       <= cmd_addr & ADDR_MASK;
                        m_axil_wdata <= cmd_wdata;
                        m_axil_wstrb <= cmd_wstrb;
                        if (cmd_write) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WR_REQ;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                            state          <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axil_bready <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= m_axil_bresp;
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b0;
                        state         <= RSP;
                    end else if (tmo_hit) begin
                        m_axil_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= 2'b10;
                        rsp_rdata     <= '1;
                        rsp_timeout   <= 1'b1;
                        orphan        <= 1'b1;
                        state         <= RSP;
                    end else if (32'(tmo_cnt) < TIMEOUT_CYCLES) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                RD_REQ: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        tmo_cnt        <= '0;
                        state          <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= m_axil_rresp;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_timeout   <= 1'b0;
                        state         <= RSP;
                    end else if (tmo_hit) begin
                        m_axil_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= 2'b10;
                        rsp_rdata     <= '1;
                        rsp_timeout   <= 1'b1;
                        orphan        <= 1'b1;
                        state         <= RSP;
                    end else if (32'(tmo_cnt) < TIMEOUT_CYCLES) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (orphan) begin
                            m_axil_bready <= is_write;
                            m_axil_rready <= !is_write;
                            state         <= ORPHAN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                ORPHAN: begin
                    // Swallow the late beat so it can never be paired with a later command.
                    if ((is_write && m_axil_bvalid) || (!is_write && m_axil_rvalid)) begin
                        m_axil_bready <= 1'b0;
                        m_axil_rready <= 1'b0;
                        orphan        <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pspin_ctrl_axil_master.sv
// Directed bench for pspin_ctrl_axil_master with a delay-configurable AXI-Lite slave model.
module tb_pspin_ctrl_axil_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    pspin_ctrl_axil_master #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    // Slave configuration, set by the stimulus before each command.
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;

    // Slave state and channel monitors.
    int          cyc = 0;
    int          aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    int          aw_beats, w_beats, b_beats, ar_beats, r_beats;
    int          awv_cyc, wv_cyc, arv_cyc;
    logic [15:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid  && (w_wait  >= w_dly);
    assign arready = arvalid && (ar_wait >= ar_dly);
    assign bvalid  = b_pend  && (b_cnt   >= b_dly);
    assign rvalid  = r_pend  && (r_cnt   >= r_dly);
    assign bresp   = s_resp;
    assign rresp   = s_resp;
    assign rdata   = s_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_beats <= 0; w_beats <= 0; b_beats <= 0; ar_beats <= 0; r_beats <= 0;
            awv_cyc <= 0; wv_cyc <= 0; arv_cyc <= 0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
        end else begin
            if (awvalid) begin awv_cyc <= awv_cyc + 1; aw_wait <= awready ? 0 : aw_wait + 1; end
            if (wvalid)  begin wv_cyc  <= wv_cyc + 1;  w_wait  <= wready  ? 0 : w_wait + 1;  end
            if (arvalid) begin arv_cyc <= arv_cyc + 1; ar_wait <= arready ? 0 : ar_wait + 1; end
            if (awvalid && awready) begin aw_beats <= aw_beats + 1; s_awaddr <= awaddr; end
            if (wvalid && wready) begin w_beats <= w_beats + 1; s_wdata <= wdata; s_wstrb <= wstrb; end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (awvalid && awready) aw_got <= 1'b1;
                if (wvalid && wready)   w_got  <= 1'b1;
            end
            if (b_pend) begin
                if (bvalid && bready) begin b_pend <= 1'b0; b_beats <= b_beats + 1; end
                else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                r_pend <= 1'b1; r_cnt <= 0; s_araddr <= araddr; ar_beats <= ar_beats + 1;
            end
            if (r_pend) begin
                if (rvalid && rready) begin r_pend <= 1'b0; r_beats <= r_beats + 1; end
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic set_slave(input int a, input int w, input int ar, input int b, input int r,
                             input logic [1:0] resp, input logic [31:0] rd);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r; s_resp = resp; s_rdata = rd;
    endtask

    // Present a command and return just after the accepting edge; acc marks cycle 0.
    task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        @(negedge clk);
        while (!rsp_valid && (cyc - acc) < 100) @(negedge clk);
        lat = rsp_valid ? (cyc - acc) : -1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        int          awd, wd, ard, bd, rd;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [15:0] exp_addr;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_req_cyc;
        int          exp_w_cyc;
    } vec_t;

    initial begin
        vec_t v[6];
        int lat, n, bad, b0, a0, w0, r0, ar0, awv0, wv0, arv0;
        logic [31:0] hold_d;
        logic [1:0]  hold_r;

        //         wr    addr      wdata         strb  awd wd ard bd rd resp   rdata         exp_addr  lat resp   rdata        req w
        v[0] = '{1'b1, 16'h1003, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        16'h1000, 3, 2'b00, 32'h0,        1, 1};
        v[1] = '{1'b1, 16'h2006, 32'h12345678, 4'h3, 0, 5, 0, 0, 0, 2'b00, 32'h0,        16'h2004, 8, 2'b00, 32'h0,        1, 6};
        v[2] = '{1'b0, 16'h0040, 32'h0,        4'h0, 0, 0, 4, 0, 0, 2'b10, 32'h3,        16'h0040, 7, 2'b10, 32'h3,        5, 0};
        v[3] = '{1'b0, 16'h0101, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 16'h0100, 3, 2'b00, 32'hCAFEF00D, 1, 0};
        v[4] = '{1'b1, 16'h00FF, 32'hA5A50001, 4'h1, 3, 0, 0, 2, 0, 2'b11, 32'h0,        16'h00FC, 8, 2'b11, 32'h0,        4, 1};
        v[5] = '{1'b0, 16'h0200, 32'h0,        4'h0, 0, 0, 0, 0, 7, 2'b00, 32'h000055AA, 16'h0200, 10, 2'b00, 32'h000055AA,  1, 0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp", {rsp_rdata[29:0], rsp_valid, rsp_timeout} | 32'(rsp_resp), 32'd0);
        chk("reset_axi_handshake", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            set_slave(v[i].awd, v[i].wd, v[i].ard, v[i].bd, v[i].rd, v[i].sresp, v[i].srdata);
            a0 = aw_beats; w0 = w_beats; b0 = b_beats; ar0 = ar_beats; r0 = r_beats;
            awv0 = awv_cyc; wv0 = wv_cyc; arv0 = arv_cyc;
            send_cmd(v[i].wr, v[i].addr, v[i].wdat, v[i].strb);
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].exp_lat));
            chk($sformatf("v%0d_resp", i), 32'(rsp_resp), 32'(v[i].exp_resp));
            chk($sformatf("v%0d_rdata", i), rsp_rdata, v[i].exp_rdata);
            chk($sformatf("v%0d_timeout", i), 32'(rsp_timeout), 32'd0);
            chk($sformatf("v%0d_cmd_ready_low", i), 32'(cmd_ready), 32'd0);
            if (v[i].wr) begin
                chk($sformatf("v%0d_awaddr", i), 32'(s_awaddr), 32'(v[i].exp_addr));
                chk($sformatf("v%0d_wdata", i), s_wdata, v[i].wdat);
                chk($sformatf("v%0d_wstrb", i), 32'(s_wstrb), 32'(v[i].strb));
                chk($sformatf("v%0d_beats_aw_w_b", i),
                    32'({8'(aw_beats - a0), 8'(w_beats - w0), 8'(b_beats - b0)}), 32'h010101);
                chk($sformatf("v%0d_awvalid_cycles", i), 32'(awv_cyc - awv0), 32'(v[i].exp_req_cyc));
                chk($sformatf("v%0d_wvalid_cycles", i), 32'(wv_cyc - wv0), 32'(v[i].exp_w_cyc));
            end else begin
                chk($sformatf("v%0d_araddr", i), 32'(s_araddr), 32'(v[i].exp_addr));
                chk($sformatf("v%0d_beats_ar_r", i),
                    32'({8'(ar_beats - ar0), 8'(r_beats - r0)}), 32'h0101);
                chk($sformatf("v%0d_arvalid_cycles", i), 32'(arv_cyc - arv0), 32'(v[i].exp_req_cyc));
            end
            consume();
        end

        // Write response timeout, then the late B is absorbed in ORPHAN.
        set_slave(0, 0, 0, 20, 0, 2'b00, 32'h0);
        b0 = b_beats;
        send_cmd(1'b1, 16'h0010, 32'h00000001, 4'hF);
        wait_rsp(lat);
        chk("tmo_latency", 32'(lat), 32'd10);
        chk("tmo_flag", 32'(rsp_timeout), 32'd1);
        chk("tmo_resp", 32'(rsp_resp), 32'd2);
        chk("tmo_rdata", rsp_rdata, 32'hFFFFFFFF);
        consume();
        @(negedge clk);
        chk("orphan_bready", 32'(bready), 32'd1);
        chk("orphan_cmd_ready", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("orphan_release_cycle", 32'(cyc - acc), 32'd23);
        chk("orphan_b_beats", 32'(b_beats - b0), 32'd1);
        set_slave(0, 0, 0, 0, 0, 2'b00, 32'h13572468);
        send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("post_orphan_latency", 32'(lat), 32'd3);
        chk("post_orphan_rdata", rsp_rdata, 32'h13572468);
        chk("post_orphan_timeout", 32'(rsp_timeout), 32'd0);
        consume();

        // Response held off by rsp_ready: outputs stable, no AXI traffic.
        set_slave(0, 0, 0, 0, 0, 2'b01, 32'h0BADF00D);
        send_cmd(1'b0, 16'h0020, 32'h0, 4'h0);
        wait_rsp(lat);
        hold_d = rsp_rdata; hold_r = rsp_resp;
        chk("stall_rdata", hold_d, 32'h0BADF00D);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== hold_d || rsp_resp !== hold_r || cmd_ready ||
                awvalid || wvalid || arvalid || bready || rready) bad++;
        end
        chk("stall_stable_cycles_bad", 32'(bad), 32'd0);
        chk("stall_resp", 32'(rsp_resp), 32'd1);
        consume();

        // Reset while the write request is outstanding.
        set_slave(50, 50, 0, 0, 0, 2'b00, 32'h0);
        send_cmd(1'b1, 16'h3000, 32'h11112222, 4'hF);
        @(negedge clk);
        chk("pre_reset_valids", 32'({awvalid, wvalid, busy}), 32'b111);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_valids", 32'({awvalid, wvalid, busy}), 32'b000);
        set_slave(0, 0, 0, 0, 0, 2'b00, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'({cmd_ready, rsp_valid}), 32'b10);
        send_cmd(1'b1, 16'h3008, 32'h33334444, 4'hC);
        wait_rsp(lat);
        chk("post_reset_latency", 32'(lat), 32'd3);
        chk("post_reset_awaddr", 32'(s_awaddr), 32'h3008);
        chk("post_reset_wdata", s_wdata, 32'h33334444);
        chk("post_reset_resp", 32'({rsp_timeout, rsp_resp}), 32'd0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
